// File: rtl/timer_regs_pkg.sv
// Register map, control/status bit positions, FSM states and the bus request
// record shared by the interval-timer master and its bus port.
package timer_regs_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_POLL_RD, S_POLL_CHK,
    S_CLR_ST, S_SNAP_WR, S_SNAP_RDL, S_SNAP_RDH, S_SNAP_DONE, S_STOP_WR
  } state_e;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] dat;
  } avm_req_t;

  function automatic logic [15:0] ctrl_start_word(input logic cont, input logic ito);
    logic [15:0] w;
    w             = '0;
    w[CTRL_START] = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

  function automatic logic [15:0] ctrl_stop_word();
    logic [15:0] w;
    w            = '0;
    w[CTRL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM link between the timer master and the 16-bit interval timer slave.
// No waitrequest: every access completes in one cycle, read data one cycle later.
interface timer_ctrl_master_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/avm_master_port.sv
// Registers one bus request per cycle onto the Avalon pins; idle cycles drive zeros.
// Flags the cycle after a read so the FSM samples the slave's registered readdata.
module avm_master_port
  import timer_regs_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  avm_req_t                   req,
  output logic                       rd_vld,
  output logic [15:0]                rd_dat,
  timer_ctrl_master_if.master        avm
);

  logic        cs_q, cs_d;
  logic        wr_n_q, wr_n_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        rd_pend_q, rd_pend_d;

  always_comb begin
    cs_d      = req.vld;
    wr_n_d    = !(req.vld && req.wr);
    addr_d    = req.vld ? req.addr : 3'd0;
    wdat_d    = (req.vld && req.wr) ? req.dat : 16'd0;
    rd_pend_d = cs_q && wr_n_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q      <= 1'b0;
      wr_n_q    <= 1'b1;
      addr_q    <= 3'd0;
      wdat_q    <= 16'd0;
      rd_pend_q <= 1'b0;
    end else begin
      cs_q      <= cs_d;
      wr_n_q    <= wr_n_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = wr_n_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = wdat_q;
  assign rd_vld             = rd_pend_q;
  assign rd_dat             = avm.avm_readdata;

endmodule

// File: rtl/timer_ctrl_master.sv
// Programs, services and snapshots the interval timer slave from hardware.
// Bus access shows on the pins in the same cycle the FSM sits in the matching state.
module timer_ctrl_master
  import timer_regs_pkg::*;
#(
  parameter int POLL_INTERVAL = 16,
  parameter int TICK_W        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_start,
  input  logic [31:0]         cfg_period,
  input  logic                cfg_continuous,
  input  logic                cfg_irq_en,
  input  logic                stop_req,
  input  logic                snap_req,
  timer_ctrl_master_if.master avm,
  input  logic                timer_irq,
  output logic                busy,
  output logic                tick,
  output logic [TICK_W-1:0]   tick_count,
  output logic                snap_valid,
  output logic [31:0]         snap_value
);

  localparam int PW = $clog2(POLL_INTERVAL);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);

  state_e            state_q, state_d;
  logic [15:0]       per_hi_q, per_hi_d;
  logic              cont_q, cont_d;
  logic              irq_en_q, irq_en_d;
  logic [PW-1:0]     poll_cnt_q, poll_cnt_d;
  logic              ign_irq_q, ign_irq_d;
  logic              stop_pend_q, stop_pend_d;
  logic [TICK_W-1:0] tick_count_q, tick_count_d;
  logic [15:0]       snap_lo_q, snap_lo_d;
  logic [31:0]       snap_value_q, snap_value_d;
  logic              snap_valid_q, snap_valid_d;

  avm_req_t          req;
  logic              rd_vld;
  logic [15:0]       rd_dat;
  logic              irq_hit;

  avm_master_port u_port (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .rd_vld  (rd_vld),
    .rd_dat  (rd_dat),
    .avm     (avm)
  );

  // The cycle right after CLR_ST may still see a re-raised irq from a zero period.
  assign irq_hit = irq_en_q && timer_irq && !ign_irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cfg_start) state_d = S_WR_PL;
      S_WR_PL:     state_d = S_WR_PH;
      S_WR_PH:     state_d = S_WR_CTRL;
      S_WR_CTRL:   state_d = S_RUN;
      S_RUN: begin
        if (stop_req || stop_pend_q)                state_d = S_STOP_WR;
        else if (irq_hit)                           state_d = S_CLR_ST;
        else if (snap_req)                          state_d = S_SNAP_WR;
        else if (!irq_en_q && poll_cnt_q == '0)     state_d = S_POLL_RD;
      end
      S_POLL_RD:   state_d = S_POLL_CHK;
      S_POLL_CHK:  state_d = (rd_vld && rd_dat[ST_TO]) ? S_CLR_ST : S_RUN;
      S_CLR_ST:    state_d = cont_q ? S_RUN : S_IDLE;
      S_SNAP_WR:   state_d = S_SNAP_RDL;
      S_SNAP_RDL:  state_d = S_SNAP_RDH;
      S_SNAP_RDH:  state_d = S_SNAP_DONE;
      S_SNAP_DONE: state_d = S_RUN;
      S_STOP_WR:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Bus request is keyed on the next state so the registered pins line up with it.
  always_comb begin
    busy = (state_q != S_IDLE);
    tick = (state_q == S_CLR_ST);
    req  = '0;
    case (state_d)
      S_WR_PL:    req = '{vld: 1'b1, wr: 1'b1, addr: REG_PERIODL, dat: cfg_period[15:0]};
      S_WR_PH:    req = '{vld: 1'b1, wr: 1'b1, addr: REG_PERIODH, dat: per_hi_q};
      S_WR_CTRL:  req = '{vld: 1'b1, wr: 1'b1, addr: REG_CONTROL,
                          dat: ctrl_start_word(cont_q, irq_en_q)};
      S_POLL_RD:  req = '{vld: 1'b1, wr: 1'b0, addr: REG_STATUS,  dat: 16'd0};
      S_CLR_ST:   req = '{vld: 1'b1, wr: 1'b1, addr: REG_STATUS,  dat: 16'd0};
      S_SNAP_WR:  req = '{vld: 1'b1, wr: 1'b1, addr: REG_SNAPL,   dat: 16'd0};
      S_SNAP_RDL: req = '{vld: 1'b1, wr: 1'b0, addr: REG_SNAPL,   dat: 16'd0};
      S_SNAP_RDH: req = '{vld: 1'b1, wr: 1'b0, addr: REG_SNAPH,   dat: 16'd0};
      S_STOP_WR:  req = '{vld: 1'b1, wr: 1'b1, addr: REG_CONTROL, dat: ctrl_stop_word()};
      default:    req = '0;
    endcase
  end

  always_comb begin
    per_hi_d     = per_hi_q;
    cont_d       = cont_q;
    irq_en_d     = irq_en_q;
    tick_count_d = tick_count_q;
    snap_lo_d    = snap_lo_q;
    snap_value_d = snap_value_q;
    poll_cnt_d   = poll_cnt_q;
    ign_irq_d    = (state_q == S_CLR_ST);
    snap_valid_d = (state_q == S_SNAP_DONE);

    if (state_q == S_IDLE && cfg_start) begin
      per_hi_d     = cfg_period[31:16];
      cont_d       = cfg_continuous;
      irq_en_d     = cfg_irq_en;
      tick_count_d = '0;
    end
    if (state_q == S_CLR_ST)    tick_count_d = tick_count_q + 1'b1;
    if (state_q == S_SNAP_RDH)  snap_lo_d    = rd_dat;
    if (state_q == S_SNAP_DONE) snap_value_d = {rd_dat, snap_lo_q};

    // Poll cadence keeps running through POLL_RD/POLL_CHK so reads stay evenly spaced.
    if ((state_d == S_RUN && state_q != S_RUN && state_q != S_POLL_CHK) ||
        state_d == S_POLL_RD)
      poll_cnt_d = POLL_RELOAD;
    else if (poll_cnt_q != '0)
      poll_cnt_d = poll_cnt_q - 1'b1;

    stop_pend_d = stop_pend_q || (stop_req && state_q != S_IDLE);
    if (state_d == S_IDLE || state_d == S_STOP_WR) stop_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_hi_q     <= 16'd0;
      cont_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      poll_cnt_q   <= '0;
      ign_irq_q    <= 1'b0;
      stop_pend_q  <= 1'b0;
      tick_count_q <= '0;
      snap_lo_q    <= 16'd0;
      snap_value_q <= 32'd0;
      snap_valid_q <= 1'b0;
    end else begin
      per_hi_q     <= per_hi_d;
      cont_q       <= cont_d;
      irq_en_q     <= irq_en_d;
      poll_cnt_q   <= poll_cnt_d;
      ign_irq_q    <= ign_irq_d;
      stop_pend_q  <= stop_pend_d;
      tick_count_q <= tick_count_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign tick_count = tick_count_q;
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Directed bench: timer_ctrl_master driving a behavioural 16-bit interval timer slave.
module tb_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic        cfg_continuous = 1'b0;
  logic        cfg_irq_en = 1'b0;
  logic        stop_req = 1'b0;
  logic        snap_req = 1'b0;
  logic        timer_irq;
  logic        busy, tick, snap_valid;
  logic [3:0]  tick_count;
  logic [31:0] snap_value;

  timer_ctrl_master_if avm_if();

  timer_ctrl_master #(.POLL_INTERVAL(16), .TICK_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .cfg_irq_en     (cfg_irq_en),
    .stop_req       (stop_req),
    .snap_req       (snap_req),
    .avm            (avm_if.master),
    .timer_irq      (timer_irq),
    .busy           (busy),
    .tick           (tick),
    .tick_count     (tick_count),
    .snap_valid     (snap_valid),
    .snap_value     (snap_value)
  );

  always #5 clk = ~clk;

  // Interval timer slave: counts period..0, sets TO at 0, reloads; a clear loses to a new TO.
  logic [15:0] s_perl, s_perh, s_snapl, s_snaph, s_rdata;
  logic [31:0] s_cnt, exp_snap;
  logic        s_to, s_run, s_cont, s_ito;
  wire         s_wr = avm_if.avm_chipselect && !avm_if.avm_write_n;
  wire         s_rd = avm_if.avm_chipselect &&  avm_if.avm_write_n;
  wire  [15:0] s_wd = avm_if.avm_writedata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_perl <= 0; s_perh <= 0; s_snapl <= 0; s_snaph <= 0; s_rdata <= 0;
      s_cnt <= 0; s_to <= 0; s_run <= 0; s_cont <= 0; s_ito <= 0; exp_snap <= 0;
    end else begin
      if (s_run) begin
        if (s_cnt == 0) begin
          s_cnt <= {s_perh, s_perl};
          if (!s_cont) s_run <= 1'b0;
        end else s_cnt <= s_cnt - 1;
      end
      if (s_wr) begin
        case (avm_if.avm_address)
          3'd1: begin
            s_ito <= s_wd[0]; s_cont <= s_wd[1];
            if (s_wd[3]) s_run <= 1'b0;
            if (s_wd[2]) s_run <= 1'b1;
          end
          3'd2: begin s_perl <= s_wd; s_cnt <= {s_perh, s_wd}; s_run <= 1'b0; end
          3'd3: begin s_perh <= s_wd; s_cnt <= {s_wd, s_perl}; s_run <= 1'b0; end
          3'd4, 3'd5: begin {s_snaph, s_snapl} <= s_cnt; exp_snap <= s_cnt; end
          default: ;
        endcase
      end
      if (s_wr && avm_if.avm_address == 3'd0) s_to <= 1'b0;
      if (s_run && s_cnt == 0) s_to <= 1'b1;
      if (s_rd) begin
        case (avm_if.avm_address)
          3'd0: s_rdata <= {14'd0, s_run, s_to};
          3'd1: s_rdata <= {14'd0, s_cont, s_ito};
          3'd2: s_rdata <= s_perl;
          3'd3: s_rdata <= s_perh;
          3'd4: s_rdata <= s_snapl;
          3'd5: s_rdata <= s_snaph;
          default: s_rdata <= 16'd0;
        endcase
      end
    end
  end
  assign avm_if.avm_readdata = s_rdata;
  assign timer_irq = s_to && s_ito;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tick = 0, n_snap = 0, n_rd = 0, n_stopwr = 0, last_rd = 0, rd_gap = 0;
  logic [31:0] snap_seen = 0;
  always @(negedge clk) begin
    if (tick) n_tick <= n_tick + 1;
    if (snap_valid) begin n_snap <= n_snap + 1; snap_seen <= snap_value; end
    if (s_rd && avm_if.avm_address == 3'd0) begin
      n_rd <= n_rd + 1; rd_gap <= cyc - last_rd; last_rd <= cyc;
    end
    if (s_wr && avm_if.avm_address == 3'd1 && s_wd == 16'h0008) n_stopwr <= n_stopwr + 1;
  end

  int n_chk = 0, n_fail = 0;
  localparam logic [31:0] BUS_IDLE = 32'h0008_0000;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] bus_word();
    return {11'd0, avm_if.avm_chipselect, avm_if.avm_write_n, avm_if.avm_address,
            avm_if.avm_writedata};
  endfunction

  function automatic logic [31:0] exp_wr(input logic [2:0] a, input logic [15:0] d);
    return {11'd0, 1'b1, 1'b0, a, d};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; cfg_start = 0; stop_req = 0; snap_req = 0;
    repeat (2) @(negedge clk);
    chk("rst_bus", bus_word(), BUS_IDLE);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_count", {28'd0, tick_count}, 0);
    chk("rst_snap", {snap_value[30:0], snap_valid} | {31'd0, tick}, 0);
    reset_n = 1'b1;
  endtask

  // Leaves the bench at the negedge where WR_PL is on the bus.
  task automatic start_cfg(input logic [31:0] per, input logic cont, input logic ien);
    @(negedge clk);
    cfg_period = per; cfg_continuous = cont; cfg_irq_en = ien; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic check_prog(input string tag, input logic [31:0] per, input logic [15:0] ctl);
    chk({tag, "_perl"}, bus_word(), exp_wr(3'd2, per[15:0]));
    @(negedge clk);
    chk({tag, "_perh"}, bus_word(), exp_wr(3'd3, per[31:16]));
    @(negedge clk);
    chk({tag, "_ctrl"}, bus_word(), exp_wr(3'd1, ctl));
  endtask

  task automatic wait_tick(input string tag, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick) begin at = cyc; break; end
    end
    chk({tag, "_tick_seen"}, {31'd0, at >= 0}, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c, t0, t1, b_tick, b_snap, b_rd, b_stop;

    // Continuous irq mode, period 9: 10-cycle tick cadence, then stop racing an irq.
    do_reset();
    start_cfg(32'h0000_0009, 1'b1, 1'b1);
    check_prog("t1", 32'h0000_0009, 16'h0007);
    c = cyc;
    @(negedge clk);
    chk("t1_run_bus_idle", bus_word(), BUS_IDLE);
    wait_tick("t1a", 40, t0);
    chk("t1_first_lat", t0 - c, 12);
    @(negedge clk);
    chk("t1_count1", {28'd0, tick_count}, 1);
    for (int k = 2; k <= 3; k++) begin
      wait_tick("t1b", 20, t1);
      chk("t1_gap", t1 - t0, 10);
      t0 = t1;
      @(negedge clk);
      chk("t1_countk", {28'd0, tick_count}, k);
    end
    for (int i = 0; i < 20; i++) begin
      if (timer_irq) break;
      @(negedge clk);
    end
    chk("t1_irq_high", {31'd0, timer_irq}, 1);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    chk("t1_stop_wr", bus_word(), exp_wr(3'd1, 16'h0008));
    chk("t1_no_tick", {31'd0, tick}, 0);
    @(negedge clk);
    chk("t1_idle", {31'd0, busy}, 0);
    chk("t1_count_kept", {28'd0, tick_count}, 3);

    // One-shot poll mode, period 20: two status reads 16 apart, one tick.
    do_reset();
    b_rd = n_rd; b_tick = n_tick;
    start_cfg(32'd20, 1'b0, 1'b0);
    check_prog("t2", 32'd20, 16'h0004);
    wait_tick("t2", 80, t0);
    @(negedge clk);
    chk("t2_idle", {31'd0, busy}, 0);
    chk("t2_count", {28'd0, tick_count}, 1);
    repeat (40) @(negedge clk);
    @(posedge clk);
    chk("t2_reads", n_rd - b_rd, 2);
    chk("t2_read_gap", rd_gap, 16);
    chk("t2_ticks", n_tick - b_tick, 1);
    chk("t2_slave_run", {31'd0, s_run}, 0);

    // Snapshot in RUN with a stop arriving mid-snapshot.
    do_reset();
    b_snap = n_snap; b_stop = n_stopwr; b_tick = n_tick;
    start_cfg(32'h0001_0000, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    chk("t3_snap_wr", bus_word(), exp_wr(3'd4, 16'd0));
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    wait_idle("t3", 20);
    @(posedge clk);
    chk("t3_snap_once", n_snap - b_snap, 1);
    chk("t3_snap_val", snap_seen, exp_snap);
    chk("t3_snap_out", snap_value, exp_snap);
    chk("t3_snap_range", {31'd0, snap_value <= 32'h0001_0000}, 1);
    chk("t3_stop_wr", n_stopwr - b_stop, 1);
    chk("t3_no_tick", n_tick - b_tick, 0);

    // Period 0, 4-bit counter: 16 timeouts wrap to 0, the 17th reads 1.
    do_reset();
    start_cfg(32'd0, 1'b1, 1'b1);
    for (int n = 1; n <= 17; n++) begin
      wait_tick("t4", 12, t0);
      @(negedge clk);
      if (n == 16) chk("t4_wrap0", {28'd0, tick_count}, 0);
      if (n == 17) chk("t4_wrap1", {28'd0, tick_count}, 1);
    end
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    wait_idle("t4", 10);
    chk("t4_count_after_stop", {28'd0, tick_count}, 1);

    // Reset landing in WR_PH, then a clean restart.
    start_cfg(32'd4, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_in_wrph", bus_word(), exp_wr(3'd3, 16'd0));
    reset_n = 1'b0;
    #1;
    chk("t5_bus_idle", bus_word(), BUS_IDLE);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_count", {28'd0, tick_count}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    start_cfg(32'd4, 1'b0, 1'b1);
    check_prog("t5", 32'd4, 16'h0005);
    wait_tick("t5", 30, t0);
    @(negedge clk);
    chk("t5_done_idle", {31'd0, busy}, 0);
    chk("t5_done_count", {28'd0, tick_count}, 1);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
